// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: captures a 14-bit value, converts it with
// shift-add-3 over 14 cycles, then updates the digit outputs. Macro BCD_DISPLAY_CTRL_SAT_EN saturates overflow to 9999.
module bcd_display_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_in,
  input  logic        bin_valid,
  output logic        bin_ready,
  input  logic [3:0]  dp_sel,
  output logic [3:0]  hex_0_out,
  output logic [3:0]  hex_1_out,
  output logic [3:0]  hex_2_out,
  output logic [3:0]  hex_3_out,
  output logic [3:0]  dp_out,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_ITER = 4'd13;
  localparam logic [13:0] MAX_SHOWN = 14'd9999;

  state_t      state;
  logic [3:0]  iter_cnt;
  logic [13:0] bin_cap;
  logic [3:0]  dp_cap;
  logic [19:0] bcd;

  logic [19:0] bcd_adj;
  logic [3:0]  bit_idx;
  logic        next_bit;
  logic        res_ovf;
  logic [15:0] res_hex;
  logic [3:0]  res_dp;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign bin_ready = (state == IDLE);
  assign busy      = ~bin_ready;

  always_comb begin
    bcd_adj  = {add3(bcd[19:16]), add3(bcd[15:12]), add3(bcd[11:8]),
                add3(bcd[7:4]), add3(bcd[3:0])};
    bit_idx  = LAST_ITER - iter_cnt;
    next_bit = bin_cap[bit_idx];
  end

  // Fifth BCD digit is dropped in the wrapping build; ovf still reports it.
  always_comb begin
    res_ovf = (bin_cap > MAX_SHOWN);
    res_hex = bcd[15:0];
    res_dp  = dp_cap;
`ifdef BCD_DISPLAY_CTRL_SAT_EN
    if (res_ovf) begin
      res_hex = 16'h9999;
      res_dp  = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      iter_cnt  <= 4'd0;
      bin_cap   <= 14'd0;
      dp_cap    <= 4'd0;
      bcd       <= 20'd0;
      hex_0_out <= 4'd0;
      hex_1_out <= 4'd0;
      hex_2_out <= 4'd0;
      hex_3_out <= 4'd0;
      dp_out    <= 4'd0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bin_valid) begin
            bin_cap  <= bin_in;
            dp_cap   <= dp_sel;
            bcd      <= 20'd0;
            iter_cnt <= 4'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[18:0], next_bit};
          if (iter_cnt == LAST_ITER) begin
            state <= DONE;
          end else begin
            iter_cnt <= iter_cnt + 4'd1;
          end
        end
        DONE: begin
          hex_0_out <= res_hex[3:0];
          hex_1_out <= res_hex[7:4];
          hex_2_out <= res_hex[11:8];
          hex_3_out <= res_hex[15:12];
          dp_out    <= res_dp;
          ovf       <= res_ovf;
          iter_cnt  <= 4'd0;
          state     <= IDLE;
        end
        default: begin
          iter_cnt <= 4'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: table of conversions plus hand-written
// sequences for held-valid throughput and reset abort. Expectations follow BCD_DISPLAY_CTRL_SAT_EN.
module tb_bcd_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic [3:0]  dp_sel;
  logic [3:0]  hex_0_out, hex_1_out, hex_2_out, hex_3_out;
  logic [3:0]  dp_out;
  logic        busy;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] shown_hex;
  logic [3:0]  shown_dp;
  logic        shown_ovf;

  bcd_display_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .dp_sel    (dp_sel),
    .hex_0_out (hex_0_out),
    .hex_1_out (hex_1_out),
    .hex_2_out (hex_2_out),
    .hex_3_out (hex_3_out),
    .dp_out    (dp_out),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    logic [3:0]  d;
    logic [15:0] hex;
    logic        o;
    string       name;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [15:0] hex_now();
    return {hex_3_out, hex_2_out, hex_1_out, hex_0_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transfer: accept, 14 SHIFT edges + DONE, result on the 15th edge.
  task automatic do_conv(input logic [13:0] v, input logic [3:0] d,
                         input logic [15:0] raw_hex, input logic o, input string name);
    logic [15:0] eh;
    logic [3:0]  ed;
    bit          hold_ok;
    bit          rdy_ok;
    int          w;
    eh = raw_hex;
    ed = d;
`ifdef BCD_DISPLAY_CTRL_SAT_EN
    if (o) begin
      eh = 16'h9999;
      ed = 4'b1111;
    end
`endif
    w = 0;
    @(negedge clk);
    while (!bin_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({name, " ready_before"}, 32'(bin_ready), 32'd1);
    bin_in    = v;
    dp_sel    = d;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    bin_in    = ~v;
    dp_sel    = ~d;
    hold_ok   = 1'b1;
    rdy_ok    = (bin_ready === 1'b0) && (busy === 1'b1);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (hex_now() !== shown_hex || dp_out !== shown_dp || ovf !== shown_ovf) hold_ok = 1'b0;
      if (bin_ready !== 1'b0 || busy !== 1'b1) rdy_ok = 1'b0;
    end
    check({name, " hold"}, 32'(hold_ok), 32'd1);
    check({name, " ready_low"}, 32'(rdy_ok), 32'd1);
    @(posedge clk);
    #1;
    check({name, " hex"}, 32'(hex_now()), 32'(eh));
    check({name, " dp"}, 32'(dp_out), 32'(ed));
    check({name, " ovf"}, 32'(ovf), 32'(o));
    check({name, " ready_after"}, 32'({bin_ready, busy}), 32'b10);
    shown_hex = eh;
    shown_dp  = ed;
    shown_ovf = o;
  endtask

  initial begin
    bit seen_bad;

    tbl[0] = '{14'd1234,  4'b0100, 16'h1234, 1'b0, "v1234"};
    tbl[1] = '{14'd0,     4'b0000, 16'h0000, 1'b0, "v0"};
    tbl[2] = '{14'd9999,  4'b0011, 16'h9999, 1'b0, "v9999"};
    tbl[3] = '{14'd12345, 4'b0001, 16'h2345, 1'b1, "v12345"};
    tbl[4] = '{14'd10000, 4'b1000, 16'h0000, 1'b1, "v10000"};
    tbl[5] = '{14'd10,    4'b0010, 16'h0010, 1'b0, "v10"};
    tbl[6] = '{14'd5000,  4'b0101, 16'h5000, 1'b0, "v5000"};

    rst       = 1'b0;
    bin_valid = 1'b1;
    bin_in    = 14'd777;
    dp_sel    = 4'b1111;
    shown_hex = 16'h0000;
    shown_dp  = 4'd0;
    shown_ovf = 1'b0;

    #22;
    check("reset hex", 32'(hex_now()), 32'h0);
    check("reset dp_ovf", 32'({dp_out, ovf}), 32'h0);
    check("reset ready_busy", 32'({bin_ready, busy}), 32'b10);
    bin_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("release ready", 32'(bin_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      do_conv(tbl[i].v, tbl[i].d, tbl[i].hex, tbl[i].o, tbl[i].name);
    end

    // bin_valid held high: accepts at edges 0, 16, 32.
    @(negedge clk);
    bin_in    = 14'd5;
    dp_sel    = 4'b0000;
    bin_valid = 1'b1;
    for (int e = 0; e <= 47; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        check("held accept0", 32'(bin_ready), 32'd0);
        bin_in = 14'd6;
      end
      if (e == 15) check("held out5", 32'({hex_now(), bin_ready}), 32'({16'h0005, 1'b1}));
      if (e == 16) begin
        check("held accept16", 32'(bin_ready), 32'd0);
        bin_in = 14'd7;
      end
      if (e == 30) check("held still5", 32'(hex_now()), 32'h0005);
      if (e == 31) check("held out6", 32'(hex_now()), 32'h0006);
      if (e == 32) begin
        check("held accept32", 32'(bin_ready), 32'd0);
        bin_valid = 1'b0;
      end
      if (e == 47) check("held out7", 32'({hex_now(), bin_ready}), 32'({16'h0007, 1'b1}));
    end
    shown_hex = 16'h0007;
    shown_dp  = 4'd0;
    shown_ovf = 1'b0;

    // Reset mid-conversion must discard the in-flight value.
    do_conv(14'd42, 4'b0010, 16'h0042, 1'b0, "v42");
    @(negedge clk);
    bin_in    = 14'd8888;
    dp_sel    = 4'b1111;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort hex", 32'(hex_now()), 32'h0);
    check("abort dp_ovf", 32'({dp_out, ovf}), 32'h0);
    check("abort ready", 32'(bin_ready), 32'd1);
    shown_hex = 16'h0000;
    shown_dp  = 4'd0;
    shown_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort release ready", 32'(bin_ready), 32'd1);
    seen_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (hex_now() !== 16'h0000 || bin_ready !== 1'b1) seen_bad = 1'b1;
    end
    check("abort no 8888", 32'(seen_bad), 32'd0);
    do_conv(14'd16383, 4'b1010, 16'h6383, 1'b1, "v16383");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
